fetch_stage: RTL and testbench

- Instruction fetch stage of the RV32I core, directly upstream of the instruction decoder.
- Owns the program counter and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small in-order FIFO and presents one instruction per cycle, with its PC, under a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing buffered and in-flight fetches.

---
 rtl/fetch_stage.sv | 193 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// RV32I fetch: owns the PC, issues word reads with a credit limit of DEPTH, queues returns in order.
// Latency grant -> rvalid -> o_valid one cycle later; when the queue fills, requests stop and outputs hold.

module fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    push_vld,
   input  logic [WIDTH-1:0]        push_dat,
   input  logic                    pop_rdy,
   output logic [WIDTH-1:0]        head_dat,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_push  = push_vld && (count_q != (AW+1)'(DEPTH));
      do_pop   = pop_rdy && (count_q != '0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // flush wins over a same-cycle push or pop
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_dat = mem_q[rd_ptr_q];
   assign empty    = (count_q == '0);
   assign count    = count_q;
endmodule

module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        o_im_req,
   output logic [31:0] o_im_addr,
   input  logic        i_im_gnt,
   input  logic        i_im_rvalid,
   input  logic [31:0] i_im_rdata,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc,
   output logic        o_valid,
   input  logic        i_ready
);
   localparam int          CW      = $clog2(DEPTH) + 1;
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_ent_t;

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_q, drop_d;
   logic          run_q, run_d;

   logic          im_xfer;
   logic          rsp_vld;
   logic          rsp_keep;
   logic          push_vld;
   logic          pop_rdy;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [31:0]   redirect_tgt;
   fetch_ent_t    push_dat;
   fetch_ent_t    head_dat;

   assign redirect_tgt = i_redirect_pc & ~32'h0000_0003;

   // Credits cover both in-flight and buffered words, so the FIFO can never overflow.
   always_comb begin
      o_im_req  = run_q && !i_redirect &&
                  (({1'b0, outstanding_q} + {1'b0, fifo_count}) < CREDITS);
      o_im_addr = pc_q;
      im_xfer   = o_im_req && i_im_gnt;
      rsp_vld   = i_im_rvalid && (outstanding_q != '0);
      rsp_keep  = rsp_vld && (drop_q == '0);
      push_vld  = rsp_keep && !i_redirect;
      push_dat  = '{pc: resp_pc_q, inst: i_im_rdata};
      pop_rdy   = !fifo_empty && i_ready;
   end

   always_comb begin
      run_d         = 1'b1;
      pc_d          = pc_q;
      resp_pc_d     = resp_pc_q;
      drop_d        = drop_q;
      outstanding_d = outstanding_q + CW'(im_xfer) - CW'(rsp_vld);
      if (im_xfer) begin
         pc_d = pc_q + 32'd4;
      end
      if (rsp_vld && (drop_q != '0)) begin
         drop_d = drop_q - CW'(1);
      end
      if (rsp_keep) begin
         resp_pc_d = resp_pc_q + 32'd4;
      end
      // every fetch still in flight after this edge belongs to the old path
      if (i_redirect) begin
         pc_d      = redirect_tgt;
         resp_pc_d = redirect_tgt;
         drop_d    = outstanding_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q         <= 1'b0;
         pc_q          <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         run_q         <= run_d;
         pc_q          <= pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   fifo #(
      .WIDTH ($bits(fetch_ent_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (i_redirect),
      .push_vld (push_vld),
      .push_dat (push_dat),
      .pop_rdy  (pop_rdy),
      .head_dat (head_dat),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   always_comb begin
      o_valid = !fifo_empty;
      o_inst  = o_valid ? head_dat.inst : NOP;
      o_pc    = o_valid ? head_dat.pc   : 32'h0;
   end

   a_rvalid_credited: assert property (@(posedge clk) disable iff (!rst_n)
      i_im_rvalid |-> (outstanding_q != '0));
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a one-cycle-latency memory model feeds either a default
// instance or one with RESET_PC near the top of the address space.
module tb_fetch_stage;
   logic        clk;
   logic        rst_n;
   logic        sel;
   logic        im_gnt, im_rvalid;
   logic [31:0] im_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ready;
   bit          gnt_en, rsp_en;

   logic        req1, valid1, req2, valid2;
   logic [31:0] addr1, inst1, pc1, addr2, inst2, pc2;
   logic        gnt1, gnt2, rv1, rv2, redir2;
   logic        m_req, m_valid;
   logic [31:0] m_addr, m_pc, m_inst;

   logic [31:0] pend[$];
   logic [31:0] got_pc[$];
   logic [31:0] got_inst[$];
   int          n_checks = 0;
   int          n_pass = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign gnt1   = im_gnt & ~sel;
   assign gnt2   = im_gnt & sel;
   assign rv1    = im_rvalid & ~sel;
   assign rv2    = im_rvalid & sel;
   assign redir2 = redirect & sel;
   assign m_req   = sel ? req2 : req1;
   assign m_addr  = sel ? addr2 : addr1;
   assign m_valid = sel ? valid2 : valid1;
   assign m_pc    = sel ? pc2 : pc1;
   assign m_inst  = sel ? inst2 : inst1;

   fetch_stage dut1 (
      .clk(clk), .rst_n(rst_n), .o_im_req(req1), .o_im_addr(addr1), .i_im_gnt(gnt1),
      .i_im_rvalid(rv1), .i_im_rdata(im_rdata), .i_redirect(redirect & ~sel),
      .i_redirect_pc(redirect_pc), .o_inst(inst1), .o_pc(pc1), .o_valid(valid1),
      .i_ready(ready)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
      .clk(clk), .rst_n(rst_n), .o_im_req(req2), .o_im_addr(addr2), .i_im_gnt(gnt2),
      .i_im_rvalid(rv2), .i_im_rdata(im_rdata), .i_redirect(redir2),
      .i_redirect_pc(redirect_pc), .o_inst(inst2), .o_pc(pc2), .o_valid(valid2),
      .i_ready(ready)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[31:2], 2'b11} ^ 32'h5A00_0000;
   endfunction

   task automatic drive_mem();
      im_gnt    = gnt_en;
      im_rvalid = rsp_en && (pend.size() != 0);
      im_rdata  = 32'h0;
      if (im_rvalid) im_rdata = inst_of(pend[0]);
   endtask

   // One clock: sample handshakes before the edge, update the memory model after it.
   task automatic tick();
      logic xfer, cons, hs;
      logic [31:0] a, hpc, hinst;
      @(negedge clk);
      xfer = m_req & im_gnt;
      a = m_addr;
      cons = im_rvalid;
      hs = m_valid & ready;
      hpc = m_pc;
      hinst = m_inst;
      @(posedge clk);
      #1;
      if (cons && pend.size() != 0) void'(pend.pop_front());
      if (xfer && rst_n) pend.push_back(a);
      if (hs && rst_n) begin
         got_pc.push_back(hpc);
         got_inst.push_back(hinst);
      end
      drive_mem();
   endtask

   task automatic run_until(input int n, input int budget);
      int b = budget;
      while (got_pc.size() < n && b > 0) begin
         tick();
         b--;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sel = 1'b0;
      redirect = 1'b0;
      gnt_en = 1'b0;
      rsp_en = 1'b0;
      pend.delete();
      drive_mem();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      got_pc.delete();
      got_inst.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sel = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b1;
      gnt_en = 1'b0; rsp_en = 1'b0;
      drive_mem();
      #2;
      n_checks++; if (valid1 !== 1'b0) $display("FAIL rst_valid got %b want 0", valid1); else n_pass++;
      n_checks++; if (inst1 !== 32'h13) $display("FAIL rst_inst got %h want 00000013", inst1); else n_pass++;
      n_checks++; if (pc1 !== 32'h0) $display("FAIL rst_pc got %h want 0", pc1); else n_pass++;
      n_checks++; if (req1 !== 1'b0) $display("FAIL rst_req got %b want 0", req1); else n_pass++;
      n_checks++; if (req2 !== 1'b0) $display("FAIL rst_req2 got %b want 0", req2); else n_pass++;
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++; if ({req1, addr1} !== {1'b1, 32'h0}) $display("FAIL first_req got %b/%h want 1/00000000", req1, addr1); else n_pass++;
      n_checks++; if ({req2, addr2} !== {1'b1, 32'hFFFF_FFF8}) $display("FAIL first_req2 got %b/%h want 1/fffffff8", req2, addr2); else n_pass++;
   endtask

   task automatic test_stream();
      logic [31:0] exp [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
      do_reset();
      gnt_en = 1'b1; rsp_en = 1'b1; ready = 1'b1;
      drive_mem();
      tick();
      n_checks++; if (valid1 !== 1'b0) $display("FAIL stream_early_valid got %b want 0", valid1); else n_pass++;
      tick();
      n_checks++; if ({valid1, pc1} !== {1'b1, 32'h0}) $display("FAIL stream_first got %b/%h want 1/00000000", valid1, pc1); else n_pass++;
      run_until(4, 30);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (i >= got_pc.size()) $display("FAIL stream[%0d] got none want pc %h", i, exp[i]);
         else if (got_pc[i] !== exp[i] || got_inst[i] !== inst_of(exp[i]))
            $display("FAIL stream[%0d] got %h/%h want %h/%h", i, got_pc[i], got_inst[i], exp[i], inst_of(exp[i]));
         else n_pass++;
      end
   endtask

   task automatic test_hold();
      logic [31:0] exp [3] = '{32'h0, 32'h4, 32'h8};
      do_reset();
      gnt_en = 1'b1; rsp_en = 1'b1; ready = 1'b0;
      drive_mem();
      repeat (5) tick();
      n_checks++; if (req1 !== 1'b0) $display("FAIL hold_req got %b want 0", req1); else n_pass++;
      n_checks++; if ({valid1, pc1} !== {1'b1, 32'h0}) $display("FAIL hold_head got %b/%h want 1/00000000", valid1, pc1); else n_pass++;
      n_checks++; if (got_pc.size() != 0) $display("FAIL hold_handoffs got %0d want 0", got_pc.size()); else n_pass++;
      ready = 1'b1;
      run_until(3, 30);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (i >= got_pc.size()) $display("FAIL hold[%0d] got none want pc %h", i, exp[i]);
         else if (got_pc[i] !== exp[i] || got_inst[i] !== inst_of(exp[i]))
            $display("FAIL hold[%0d] got %h/%h want %h/%h", i, got_pc[i], got_inst[i], exp[i], inst_of(exp[i]));
         else n_pass++;
      end
   endtask

   task automatic test_redirect_outstanding();
      logic [31:0] exp [2] = '{32'h100, 32'h104};
      do_reset();
      gnt_en = 1'b1; rsp_en = 1'b0; ready = 1'b1;
      drive_mem();
      tick();
      tick();
      n_checks++; if (req1 !== 1'b0) $display("FAIL redir_credit_req got %b want 0", req1); else n_pass++;
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      tick();
      redirect = 1'b0;
      n_checks++; if (dut1.drop_q !== 2'd2) $display("FAIL redir_drop got %0d want 2", dut1.drop_q); else n_pass++;
      n_checks++; if (valid1 !== 1'b0) $display("FAIL redir_valid got %b want 0", valid1); else n_pass++;
      rsp_en = 1'b1;
      drive_mem();
      run_until(2, 30);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (i >= got_pc.size()) $display("FAIL redir[%0d] got none want pc %h", i, exp[i]);
         else if (got_pc[i] !== exp[i] || got_inst[i] !== inst_of(exp[i]))
            $display("FAIL redir[%0d] got %h/%h want %h/%h", i, got_pc[i], got_inst[i], exp[i], inst_of(exp[i]));
         else n_pass++;
      end
      n_checks++; if (dut1.drop_q !== 2'd0) $display("FAIL redir_drop_end got %0d want 0", dut1.drop_q); else n_pass++;
   endtask

   task automatic test_redirect_collide();
      logic [31:0] exp [2] = '{32'h200, 32'h204};
      do_reset();
      gnt_en = 1'b1; rsp_en = 1'b1; ready = 1'b1;
      drive_mem();
      tick();
      n_checks++; if ({req1, addr1, im_rvalid} !== {1'b1, 32'h4, 1'b1}) $display("FAIL coll_setup got %b/%h/%b want 1/00000004/1", req1, addr1, im_rvalid); else n_pass++;
      redirect = 1'b1; redirect_pc = 32'h0000_0200;
      #1;
      n_checks++; if (req1 !== 1'b0) $display("FAIL coll_req_masked got %b want 0", req1); else n_pass++;
      tick();
      redirect = 1'b0;
      #1;
      n_checks++; if (valid1 !== 1'b0) $display("FAIL coll_valid got %b want 0", valid1); else n_pass++;
      n_checks++; if ({req1, addr1} !== {1'b1, 32'h200}) $display("FAIL coll_next_req got %b/%h want 1/00000200", req1, addr1); else n_pass++;
      run_until(2, 30);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (i >= got_pc.size()) $display("FAIL coll[%0d] got none want pc %h", i, exp[i]);
         else if (got_pc[i] !== exp[i] || got_inst[i] !== inst_of(exp[i]))
            $display("FAIL coll[%0d] got %h/%h want %h/%h", i, got_pc[i], got_inst[i], exp[i], inst_of(exp[i]));
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp [2] = '{32'h404, 32'h408};
      do_reset();
      gnt_en = 1'b1; rsp_en = 1'b1; ready = 1'b1;
      drive_mem();
      repeat (3) tick();
      redirect = 1'b1; redirect_pc = 32'h0000_0300;
      tick();
      redirect_pc = 32'h0000_0407;
      tick();
      redirect = 1'b0;
      #1;
      n_checks++; if ({valid1, req1, addr1} !== {1'b0, 1'b1, 32'h404}) $display("FAIL b2b_state got %b/%b/%h want 0/1/00000404", valid1, req1, addr1); else n_pass++;
      got_pc.delete();
      got_inst.delete();
      run_until(2, 30);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (i >= got_pc.size()) $display("FAIL b2b[%0d] got none want pc %h", i, exp[i]);
         else if (got_pc[i] !== exp[i]) $display("FAIL b2b[%0d] got %h want %h", i, got_pc[i], exp[i]);
         else n_pass++;
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
      do_reset();
      sel = 1'b1;
      gnt_en = 1'b1; rsp_en = 1'b1; ready = 1'b1;
      drive_mem();
      #1;
      n_checks++; if ({m_req, m_addr} !== {1'b1, 32'hFFFF_FFF8}) $display("FAIL wrap_req got %b/%h want 1/fffffff8", m_req, m_addr); else n_pass++;
      run_until(3, 30);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (i >= got_pc.size()) $display("FAIL wrap[%0d] got none want pc %h", i, exp[i]);
         else if (got_pc[i] !== exp[i] || got_inst[i] !== inst_of(exp[i]))
            $display("FAIL wrap[%0d] got %h/%h want %h/%h", i, got_pc[i], got_inst[i], exp[i], inst_of(exp[i]));
         else n_pass++;
      end
      gnt_en = 1'b0; rsp_en = 1'b0;
      drive_mem();
   endtask

   task automatic test_midreset();
      logic [31:0] exp [2] = '{32'h0, 32'h4};
      do_reset();
      gnt_en = 1'b1; rsp_en = 1'b1; ready = 1'b0;
      drive_mem();
      tick();
      rsp_en = 1'b0;
      tick();
      n_checks++; if ({valid1, pc1, dut1.outstanding_q} !== {1'b1, 32'h0, 2'd1}) $display("FAIL mid_setup got %b/%h/%0d want 1/00000000/1", valid1, pc1, dut1.outstanding_q); else n_pass++;
      gnt_en = 1'b0;
      rst_n = 1'b0;
      drive_mem();
      #1;
      n_checks++; if ({valid1, inst1, pc1, req1} !== {1'b0, 32'h13, 32'h0, 1'b0}) $display("FAIL mid_rst_out got %b/%h/%h/%b want 0/00000013/00000000/0", valid1, inst1, pc1, req1); else n_pass++;
      rsp_en = 1'b1;
      drive_mem();
      tick();
      n_checks++; if ({valid1, dut1.outstanding_q} !== {1'b0, 2'd0}) $display("FAIL mid_late_rvalid got %b/%0d want 0/0", valid1, dut1.outstanding_q); else n_pass++;
      tick();
      pend.delete();
      drive_mem();
      rst_n = 1'b1;
      tick();
      n_checks++; if ({req1, addr1} !== {1'b1, 32'h0}) $display("FAIL mid_restart got %b/%h want 1/00000000", req1, addr1); else n_pass++;
      gnt_en = 1'b1; ready = 1'b1;
      drive_mem();
      got_pc.delete();
      got_inst.delete();
      run_until(2, 30);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (i >= got_pc.size()) $display("FAIL mid[%0d] got none want pc %h", i, exp[i]);
         else if (got_pc[i] !== exp[i] || got_inst[i] !== inst_of(exp[i]))
            $display("FAIL mid[%0d] got %h/%h want %h/%h", i, got_pc[i], got_inst[i], exp[i], inst_of(exp[i]));
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_hold();
      test_redirect_outstanding();
      test_redirect_collide();
      test_back_to_back();
      test_wrap();
      test_midreset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
